iter_controller: RTL and testbench
==================================

ITER_CONTROLLER -- requirements
Module: iter_controller

Interface
REQ-001 Parameter SIZE, default 8, SHALL set the width of the iteration count and terminal value; it matches the SIZE of the downstream counter.
REQ-002 clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-003 rst_n  input  1  SHALL be an asynchronous, active-low reset.
REQ-004 start  input  1  SHALL request a new run; it is sampled only in IDLE and FINISH.
REQ-005 stall  input  1  SHALL, when high in RUN, suppress counting for that cycle.
REQ-006 abort  input  1  SHALL cancel an active run when high in LOAD or RUN.
REQ-007 last  input  SIZE  SHALL carry the iteration count N, captured on an accepted start.
REQ-008 cnt  input  SIZE  SHALL carry the current value of the downstream counter.
REQ-009 rsc  output  1  SHALL drive the counter's synchronous clear.
REQ-010 ce  output  1  SHALL drive the counter's count enable.
REQ-011 ld  output  1  SHALL be a one-cycle strobe that loads datapath operands.
REQ-012 busy  output  1  SHALL be high while a run is in progress.
REQ-013 done  output  1  SHALL be a one-cycle completion pulse.

Function
REQ-014 The FSM SHALL have the states IDLE, LOAD, RUN and FINISH.
REQ-015 IDLE: with start=1 at the edge, N_q SHALL be loaded from last and the next state SHALL be LOAD; otherwise the FSM SHALL stay in IDLE.
REQ-016 LOAD: rsc=1 and ld=1 for exactly one cycle; the next state SHALL be RUN if N_q!=0, or FINISH if N_q==0.
REQ-017 RUN: ce SHALL equal ~stall & ~abort, combinationally.
REQ-018 RUN: when ce=1 and cnt==N_q-1, the next state SHALL be FINISH; otherwise the FSM SHALL stay in RUN.
REQ-019 FINISH: done=1 for one cycle; start=1 SHALL go to LOAD (back-to-back run, N_q recaptured); otherwise the next state SHALL be IDLE.
REQ-020 busy SHALL be 1 in LOAD and RUN, and 0 in IDLE and FINISH.
REQ-021 rsc, ld and done SHALL be Moore outputs decoded from state only; ce SHALL be 0 outside RUN.
REQ-022 Abort in LOAD or RUN SHALL force rsc=1 and ce=0 in that cycle, set the next state to IDLE, and produce no done pulse; abort in IDLE or FINISH SHALL be ignored.
REQ-023 Abort and stall together SHALL resolve to abort.
REQ-024 start while busy=1 SHALL be ignored, and N_q SHALL remain unchanged.
REQ-025 Latency: start accepted at edge k -> LOAD in cycle k+1 -> RUN from k+2; with no stalls, done SHALL be high in cycle k+2+N and cnt SHALL equal N then.
REQ-026 Each stalled cycle SHALL delay done by exactly one cycle.
REQ-027 N_q=2^SIZE-1 SHALL complete with cnt=2^SIZE-1 and no wrap; the compare SHALL be SIZE-bit unsigned, with N_q-1 computed only when N_q!=0.

Reset
REQ-028 rst_n=0 SHALL immediately set state=IDLE, N_q=0, and rsc=ce=ld=busy=done=0, including mid-run.
REQ-029 After reset release, the counter value SHALL be treated as undefined until the next LOAD clears it.

Structure
REQ-030 Package iter_pkg SHALL hold the state enum type and the state-width constant; SIZE stays a module parameter.
REQ-031 iter_controller SHALL contain no sub-module; it SHALL pair with the counter in an integration top, iter_unit, which a bench SHALL also instantiate.

Verification
REQ-032 SIZE=8, last=5, start pulse, no stall -> rsc/ld high 1 cycle, ce high 5 cycles, done in cycle k+7, cnt=5.
REQ-033 last=5, stall high in the 2nd and 3rd RUN cycles -> done in cycle k+9, cnt=5, ce low exactly during the stalls.
REQ-034 last=0 -> LOAD then FINISH, ce never high, done in cycle k+2, cnt=0.
REQ-035 last=5, abort in the 3rd RUN cycle -> rsc=1, ce=0 that cycle, IDLE next, no done, cnt=0 after the edge.
REQ-036 start held high through FINISH with last=3 then 2 -> second LOAD directly after FINISH, done pulses for cnt=3 then cnt=2; start during RUN ignored.
REQ-037 rst_n low mid-RUN (last=200, cnt=100) -> all outputs 0 asynchronously, state IDLE; last=255 run -> done with cnt=255.

Source files
------------

// File: rtl/iter_pkg.sv
// Shared types for the iteration controller: FSM state encoding and helpers.
package iter_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_RUN    = 2'd2,
        S_FINISH = 2'd3
    } iter_state_e;

    function automatic logic is_busy(iter_state_e s);
        return (s == S_LOAD) || (s == S_RUN);
    endfunction

endpackage

// File: rtl/iter_if.sv
// Handshake bundle between a run requester, the iteration controller and its counter.
interface iter_if #(parameter int SIZE = 8);

    logic            start;
    logic            stall;
    logic            abort;
    logic [SIZE-1:0] last;
    logic [SIZE-1:0] cnt;
    logic            rsc;
    logic            ce;
    logic            ld;
    logic            busy;
    logic            done;

    modport master (
        output start, stall, abort, last, cnt,
        input  rsc, ce, ld, busy, done
    );

    modport slave (
        input  start, stall, abort, last, cnt,
        output rsc, ce, ld, busy, done
    );

endinterface

// File: rtl/iter_counter.sv
// Downstream iteration counter: synchronous clear has priority over count enable.
module iter_counter #(
    parameter int SIZE = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            rsc,
    input  logic            ce,
    output logic [SIZE-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (rsc)
            cnt <= '0;
        else if (ce)
            cnt <= cnt + SIZE'(1);
    end

endmodule

// File: rtl/iter_unit.sv
// Integration top pairing the iteration controller with its counter.
module iter_unit #(
    parameter int SIZE = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            stall,
    input  logic            abort,
    input  logic [SIZE-1:0] last,
    output logic [SIZE-1:0] cnt,
    output logic            rsc,
    output logic            ce,
    output logic            ld,
    output logic            busy,
    output logic            done
);

    iter_if #(.SIZE(SIZE)) bus ();
    logic [SIZE-1:0] cnt_q;

    assign bus.start = start;
    assign bus.stall = stall;
    assign bus.abort = abort;
    assign bus.last  = last;
    assign bus.cnt   = cnt_q;

    iter_controller #(.SIZE(SIZE)) u_ctrl (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    iter_counter #(.SIZE(SIZE)) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .rsc   (bus.rsc),
        .ce    (bus.ce),
        .cnt   (cnt_q)
    );

    assign cnt  = cnt_q;
    assign rsc  = bus.rsc;
    assign ce   = bus.ce;
    assign ld   = bus.ld;
    assign busy = bus.busy;
    assign done = bus.done;

endmodule

// File: rtl/iter_controller.sv
// Sequences one counting run: clear/load, count N enabled cycles, pulse done.
//   state  | meaning
//   IDLE   | waiting for start
//   LOAD   | clear counter, strobe operand load
//   RUN    | counting, ce = ~stall & ~abort
//   FINISH | one-cycle done, may chain into LOAD
module iter_controller
    import iter_pkg::*;
#(
    parameter int SIZE = 8
) (
    input  logic  clk,
    input  logic  rst_n,
    iter_if.slave bus
);

    iter_state_e     state;
    iter_state_e     state_nxt;
    logic [SIZE-1:0] n_q;
    logic [SIZE-1:0] term;
    logic            run_ce;
    logic            hit;
    logic            rsc_q;
    logic            ld_q;
    logic            busy_q;
    logic            done_q;

    // N_q is never 0 while in RUN; the guard keeps the compare from wrapping.
    assign term   = (n_q != '0) ? (n_q - SIZE'(1)) : '0;
    assign run_ce = (state == S_RUN) && !bus.stall && !bus.abort;
    assign hit    = run_ce && (bus.cnt == term);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (bus.start) state_nxt = S_LOAD;
            S_LOAD: begin
                if (bus.abort)       state_nxt = S_IDLE;
                else if (n_q != '0)  state_nxt = S_RUN;
                else                 state_nxt = S_FINISH;
            end
            S_RUN: begin
                if (bus.abort)       state_nxt = S_IDLE;
                else if (hit)        state_nxt = S_FINISH;
            end
            S_FINISH: state_nxt = bus.start ? S_LOAD : S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Moore outputs are registered from the next state so they align with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            n_q    <= '0;
            rsc_q  <= 1'b0;
            ld_q   <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (((state == S_IDLE) || (state == S_FINISH)) && bus.start)
                n_q <= bus.last;
            rsc_q  <= (state_nxt == S_LOAD);
            ld_q   <= (state_nxt == S_LOAD);
            busy_q <= is_busy(state_nxt);
            done_q <= (state_nxt == S_FINISH);
        end
    end

    assign bus.rsc  = rsc_q | ((state == S_RUN) & bus.abort);
    assign bus.ce   = run_ce;
    assign bus.ld   = ld_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule

// File: tb/tb_iter_controller.sv
// Bench for iter_controller (with counter) and iter_unit against a run-length model.
module tb_iter_controller;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       stall = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] last = 8'd0;
    logic [7:0] c_cnt;
    logic [7:0] u_cnt;
    logic       u_rsc, u_ce, u_ld, u_busy, u_done;

    int checks = 0;
    int errors = 0;

    // Model: a run is a load cycle followed by m_rem enabled cycles still owed.
    bit m_load, m_done, m_known;
    int m_rem, m_n, m_cnt;
    bit e_ld, e_rsc, e_ce, e_busy, e_done;

    typedef struct {
        logic       s, st, ab;
        logic [7:0] l;
        logic       x_ld, x_rsc, x_ce, x_busy, x_done;
        int         x_cnt;
    } vec_t;
    vec_t tbl[11];

    iter_if #(.SIZE(8)) bus ();
    assign bus.start = start;
    assign bus.stall = stall;
    assign bus.abort = abort;
    assign bus.last  = last;
    assign bus.cnt   = c_cnt;

    iter_controller #(.SIZE(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    iter_counter #(.SIZE(8)) cnt_i (
        .clk   (clk),
        .rst_n (rst_n),
        .rsc   (bus.rsc),
        .ce    (bus.ce),
        .cnt   (c_cnt)
    );

    iter_unit #(.SIZE(8)) unit (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .stall (stall),
        .abort (abort),
        .last  (last),
        .cnt   (u_cnt),
        .rsc   (u_rsc),
        .ce    (u_ce),
        .ld    (u_ld),
        .busy  (u_busy),
        .done  (u_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_load = 0; m_done = 0; m_known = 0; m_rem = 0; m_n = 0; m_cnt = 0;
    endtask

    task automatic calc_exp();
        bit running;
        running = (m_rem > 0) && !m_load;
        e_ld   = m_load;
        e_busy = m_load || running;
        e_rsc  = m_load || (running && abort);
        e_ce   = running && !stall && !abort;
        e_done = m_done;
    endtask

    task automatic model_check();
        calc_exp();
        chk("ld",     int'(bus.ld),   int'(e_ld));
        chk("rsc",    int'(bus.rsc),  int'(e_rsc));
        chk("ce",     int'(bus.ce),   int'(e_ce));
        chk("busy",   int'(bus.busy), int'(e_busy));
        chk("done",   int'(bus.done), int'(e_done));
        chk("u_ld",   int'(u_ld),     int'(e_ld));
        chk("u_rsc",  int'(u_rsc),    int'(e_rsc));
        chk("u_ce",   int'(u_ce),     int'(e_ce));
        chk("u_busy", int'(u_busy),   int'(e_busy));
        chk("u_done", int'(u_done),   int'(e_done));
        if (m_known) begin
            chk("cnt",   int'(c_cnt), m_cnt);
            chk("u_cnt", int'(u_cnt), m_cnt);
        end
    endtask

    task automatic model_step();
        calc_exp();
        if (e_rsc) begin
            m_cnt = 0;
            m_known = 1;
        end else if (e_ce) begin
            m_cnt = (m_cnt + 1) % 256;
        end
        if (m_load) begin
            m_load = 0;
            if (!abort) begin
                if (m_n == 0) m_done = 1;
                else          m_rem = m_n;
            end
        end else if (m_rem > 0) begin
            if (abort) m_rem = 0;
            else if (!stall) begin
                m_rem--;
                if (m_rem == 0) m_done = 1;
            end
        end else begin
            m_done = 0;
            if (start) begin
                m_n = int'(last);
                m_load = 1;
            end
        end
    endtask

    task automatic drive(input logic s, input logic st, input logic ab, input logic [7:0] l);
        start = s; stall = st; abort = ab; last = l;
        #1;
        model_check();
    endtask

    task automatic advance();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    // Starts a run of length l at cycle 0, stalls in cycles sa/sb; reports the done cycle.
    task automatic run_count(input logic [7:0] l, input int sa, input int sb, input int max,
                             output int cyc, output int cnt_at);
        bit found;
        found = 0; cyc = -1; cnt_at = -1;
        for (int i = 0; i <= max && !found; i++) begin
            drive(i == 0, (i == sa) || (i == sb), 1'b0, l);
            if (i > 0 && bus.done) begin
                found = 1; cyc = i; cnt_at = int'(c_cnt);
            end
            advance();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, cv;
        model_reset();
        tbl[0] = '{1'b1, 1'b0, 1'b0, 8'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1};
        tbl[1] = '{1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, -1};
        for (int r = 2; r <= 6; r++)
            tbl[r] = '{1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, r - 2};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0};

        // Reset state
        #3;
        drive(1'b0, 1'b0, 1'b0, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table: N=5 run, then back-to-back N=0 run
        for (int r = 0; r < 11; r++) begin
            drive(tbl[r].s, tbl[r].st, tbl[r].ab, tbl[r].l);
            chk($sformatf("tbl%0d_ld", r),   int'(bus.ld),   int'(tbl[r].x_ld));
            chk($sformatf("tbl%0d_rsc", r),  int'(bus.rsc),  int'(tbl[r].x_rsc));
            chk($sformatf("tbl%0d_ce", r),   int'(bus.ce),   int'(tbl[r].x_ce));
            chk($sformatf("tbl%0d_busy", r), int'(bus.busy), int'(tbl[r].x_busy));
            chk($sformatf("tbl%0d_done", r), int'(bus.done), int'(tbl[r].x_done));
            if (tbl[r].x_cnt >= 0)
                chk($sformatf("tbl%0d_cnt", r), int'(c_cnt), tbl[r].x_cnt);
            advance();
        end

        // Stalls in 2nd and 3rd RUN cycles delay done by two
        run_count(8'd5, 3, 4, 40, cyc, cv);
        chk("stall_done_cycle", cyc, 9);
        chk("stall_done_cnt", cv, 5);
        repeat (2) begin drive(1'b0, 1'b0, 1'b0, 8'd0); advance(); end

        // Abort (with stall) in 3rd RUN cycle
        drive(1'b1, 1'b0, 1'b0, 8'd5); advance();
        drive(1'b0, 1'b0, 1'b0, 8'd0); advance();
        drive(1'b0, 1'b0, 1'b0, 8'd0); advance();
        drive(1'b0, 1'b0, 1'b0, 8'd0); advance();
        drive(1'b0, 1'b1, 1'b1, 8'd0);
        chk("abort_rsc", int'(bus.rsc), 1);
        chk("abort_ce", int'(bus.ce), 0);
        advance();
        drive(1'b0, 1'b0, 1'b0, 8'd0);
        chk("abort_busy", int'(bus.busy), 0);
        chk("abort_cnt", int'(c_cnt), 0);
        advance();
        repeat (3) begin
            drive(1'b0, 1'b0, 1'b0, 8'd0);
            chk("abort_nodone", int'(bus.done), 0);
            advance();
        end

        // start held through FINISH: last=3 then 2; last=9 offered during RUN is ignored
        for (int i = 0; i <= 10; i++) begin
            drive(i <= 5, 1'b0, 1'b0, (i == 0) ? 8'd3 : ((i == 5) ? 8'd2 : 8'd9));
            if (i == 5) begin
                chk("b2b_done1", int'(bus.done), 1);
                chk("b2b_cnt1", int'(c_cnt), 3);
            end
            if (i == 6) chk("b2b_ld2", int'(bus.ld), 1);
            if (i == 9) begin
                chk("b2b_done2", int'(bus.done), 1);
                chk("b2b_cnt2", int'(c_cnt), 2);
            end
            advance();
        end

        // Asynchronous reset mid-run at cnt=100
        drive(1'b1, 1'b0, 1'b0, 8'd200); advance();
        for (int i = 0; i < 101; i++) begin drive(1'b0, 1'b0, 1'b0, 8'd0); advance(); end
        chk("mid_cnt", int'(c_cnt), 100);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_rsc", int'(bus.rsc), 0);
        chk("rst_ce", int'(bus.ce), 0);
        chk("rst_ld", int'(bus.ld), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_u_busy", int'(u_busy), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Full-scale run completes without wrap
        run_count(8'd255, -1, -1, 300, cyc, cv);
        chk("max_done_cycle", cyc, 257);
        chk("max_done_cnt", cv, 255);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            logic [7:0] l;
            l = ($urandom_range(0, 15) == 0) ? 8'($urandom) : 8'($urandom_range(0, 12));
            drive($urandom_range(0, 9) < 3, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 31) == 0, l);
            advance();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
